disp_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display that shares one `decod7seg` instance across all digits. It holds a double-buffered digit store written through a valid/ready port, commits new contents only at frame boundaries to prevent tearing, and sequences digit enables with a blanking gap between digits to suppress ghosting. It sits between the coprocessor's result/status logic and the board's segment and digit-select pins.

---
 rtl/disp_pkg.sv | 19 +
 rtl/decod7seg.sv | 31 +++
 rtl/disp_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package disp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } scan_state_e;

  // One digit slot: hex nibble plus a forced-blank flag.
  typedef struct packed {
    logic       off;
    logic [3:0] nib;
  } digit_t;

  localparam logic [6:0] SEG_OFF      = 7'h7F;
  localparam digit_t     DIGIT_RESET  = '{off: 1'b1, nib: 4'h0};

endpackage

// File: rtl/decod7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module decod7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Combinational glyph lookup.
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with double-buffered digits,
// frame-synchronous commit and a blanking gap before each digit is lit.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(NDIG)-1:0] wr_addr,
  input  logic [3:0]              wr_data,
  input  logic                    wr_off,
  input  logic                    commit,
  output logic [6:0]              seg,
  output logic [NDIG-1:0]         dig_n,
  output logic                    frame_tick
);

  localparam int AW = $clog2(NDIG);
  localparam int CW = $clog2(PRESCALE);

  localparam logic [CW-1:0]   CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0]   SHOW_LAST  = CW'(PRESCALE - BLANK - 1);
  localparam logic [AW-1:0]   IDX_ZERO   = AW'(0);
  localparam logic [AW-1:0]   IDX_ONE    = AW'(1);
  localparam logic [AW-1:0]   IDX_LAST   = AW'(NDIG - 1);
  localparam logic [AW:0]     NDIG_W     = (AW + 1)'(NDIG);
  localparam logic [NDIG-1:0] DIG_ALLOFF = {NDIG{1'b1}};
  localparam logic [NDIG-1:0] DIG_ONE    = {{(NDIG - 1){1'b0}}, 1'b1};

  scan_state_e     state_r, state_nx_s;
  logic [AW-1:0]   idx_r, idx_nx_s;
  logic [CW-1:0]   cnt_r, cnt_nx_s;
  logic            pend_r;
  digit_t          shadow_r [NDIG];
  digit_t          active_r [NDIG];

  logic [6:0]      seg_r, seg_nx_s, dec_seg_s;
  logic [NDIG-1:0] dig_n_r, dig_n_nx_s;
  logic            tick_r, tick_nx_s;
  logic            frame_end_s;
  logic            wr_addr_ok_s;
  digit_t          disp_entry_s;
  logic [3:0]      dec_in_s;

  assign wr_ready     = ~rst;
  assign wr_addr_ok_s = ({1'b0, wr_addr} < NDIG_W);
  assign frame_end_s  = (state_r == S_SHOW) && (cnt_r == SHOW_LAST) && (idx_r == IDX_LAST);
  assign disp_entry_s = active_r[idx_r];
  assign dec_in_s     = disp_entry_s.nib;

  decod7seg u_dec (
    .hex (dec_in_s),
    .seg (dec_seg_s)
  );

  // Next-state, slot counter and digit index sequencing.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    cnt_nx_s   = cnt_r;
    if (!en) begin
      state_nx_s = S_IDLE;
      idx_nx_s   = IDX_ZERO;
      cnt_nx_s   = CNT_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_nx_s = S_BLANK;
          idx_nx_s   = IDX_ZERO;
          cnt_nx_s   = CNT_ZERO;
        end
        S_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_nx_s = S_SHOW;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            cnt_nx_s   = cnt_r + CNT_ONE;
          end
        end
        S_SHOW: begin
          if (cnt_r == SHOW_LAST) begin
            state_nx_s = S_BLANK;
            cnt_nx_s   = CNT_ZERO;
            if (idx_r == IDX_LAST) begin
              idx_nx_s = IDX_ZERO;
            end else begin
              idx_nx_s = idx_r + IDX_ONE;
            end
          end else begin
            cnt_nx_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nx_s = S_IDLE;
          idx_nx_s   = IDX_ZERO;
          cnt_nx_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output lookahead so the registered pins line up with the state register.
  always_comb begin
    tick_nx_s  = (state_nx_s == S_SHOW) && (cnt_nx_s == SHOW_LAST) && (idx_nx_s == IDX_LAST);
    dig_n_nx_s = DIG_ALLOFF;
    seg_nx_s   = SEG_OFF;
    if (state_nx_s == S_SHOW) begin
      dig_n_nx_s = ~(DIG_ONE << idx_nx_s);
    end else begin
      dig_n_nx_s = DIG_ALLOFF;
    end
    if ((state_nx_s == S_IDLE) || disp_entry_s.off) begin
      seg_nx_s = SEG_OFF;
    end else begin
      seg_nx_s = dec_seg_s;
    end
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      idx_r   <= IDX_ZERO;
      cnt_r   <= CNT_ZERO;
      seg_r   <= SEG_OFF;
      dig_n_r <= DIG_ALLOFF;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      cnt_r   <= cnt_nx_s;
      seg_r   <= seg_nx_s;
      dig_n_r <= dig_n_nx_s;
      tick_r  <= tick_nx_s;
    end
  end

  // Digit store: copy reads the pre-write shadow, so a same-cycle write waits for the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        shadow_r[i] <= DIGIT_RESET;
        active_r[i] <= DIGIT_RESET;
      end
    end else begin
      if (frame_end_s && pend_r) begin
        active_r <= shadow_r;
        pend_r   <= commit;
      end else begin
        pend_r   <= pend_r | commit;
      end
      if (wr_valid && wr_addr_ok_s) begin
        shadow_r[wr_addr] <= '{off: wr_off, nib: wr_data};
      end
    end
  end

  assign seg        = seg_r;
  assign dig_n      = dig_n_r;
  assign frame_tick = tick_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench: cycle-position reference model of the scan, frame commit and store.
module tb_disp_scan_ctrl;

  localparam int N  = 4;
  localparam int P  = 20;
  localparam int B  = 4;
  localparam int N3 = 3;
  localparam int P3 = 12;
  localparam int B3 = 3;

  logic       clk = 1'b0;
  logic       rst, en, wr_valid, wr_off, commit;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_ready, frame_tick;
  logic [6:0] seg;
  logic [3:0] dig_n;

  logic       en3, wr_valid3, wr_off3, commit3;
  logic [1:0] wr_addr3;
  logic [3:0] wr_data3;
  logic       wr_ready3, frame_tick3;
  logic [6:0] seg3;
  logic [2:0] dig_n3;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [3:0] sh_nib [N];
  logic [3:0] ac_nib [N];
  logic       sh_off [N];
  logic       ac_off [N];
  bit         pend;
  bit         run;
  int         t;
  int         cyc_no = 0;
  logic [6:0] hex_tab [16];

  always #5 clk = ~clk;

  disp_scan_ctrl #(.NDIG(N), .PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_off(wr_off), .commit(commit),
    .seg(seg), .dig_n(dig_n), .frame_tick(frame_tick)
  );

  disp_scan_ctrl #(.NDIG(N3), .PRESCALE(P3), .BLANK(B3)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
    .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_off(wr_off3), .commit(commit3),
    .seg(seg3), .dig_n(dig_n3), .frame_tick(frame_tick3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  function automatic logic [6:0] expect_seg(input int i);
    return ac_off[i] ? 7'h7F : hex_tab[ac_nib[i]];
  endfunction

  // Advance the model across one clock edge using the inputs present before it.
  task automatic model_edge();
    int  ph, ix;
    bit  fe;
    if (rst) begin
      run  = 1'b0;
      t    = 0;
      pend = 1'b0;
      for (int i = 0; i < N; i++) begin
        sh_nib[i] = 4'h0; sh_off[i] = 1'b1;
        ac_nib[i] = 4'h0; ac_off[i] = 1'b1;
      end
    end else begin
      ph = t % P;
      ix = (t / P) % N;
      fe = run && (ph == P - 1) && (ix == N - 1);
      if (fe && pend) begin
        for (int i = 0; i < N; i++) begin
          ac_nib[i] = sh_nib[i];
          ac_off[i] = sh_off[i];
        end
        pend = commit;
      end else begin
        pend = pend | commit;
      end
      if (wr_valid && (int'(wr_addr) < N)) begin
        sh_nib[wr_addr] = wr_data;
        sh_off[wr_addr] = wr_off;
      end
      if (!en) begin
        run = 1'b0; t = 0;
      end else if (!run) begin
        run = 1'b1; t = 0;
      end else begin
        t++;
      end
    end
  endtask

  task automatic check_outputs();
    int         ph, ix;
    logic [3:0] exp_dig;
    chk("wr_ready", wr_ready, (!rst));
    if (!run) begin
      chk("idle_dig_n", dig_n, 4'hF);
      chk("idle_seg", seg, 7'h7F);
      chk("idle_tick", frame_tick, 1'b0);
    end else begin
      ph = t % P;
      ix = (t / P) % N;
      exp_dig = 4'hF;
      if (ph >= B) exp_dig[ix] = 1'b0;
      chk("dig_n", dig_n, exp_dig);
      chk("frame_tick", frame_tick, ((ph == P - 1) && (ix == N - 1)));
      if (ph >= B) chk("seg_show", seg, expect_seg(ix));
    end
    chk("one_low", ($countones(~dig_n) <= 1), 1'b1);
  endtask

  task automatic cyc();
    @(posedge clk);
    cyc_no++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_pos(input int ix, input int ph, input int budget);
    int n = 0;
    while (!(run && ((t % P) == ph) && (((t / P) % N) == ix)) && (n < budget)) begin
      cyc();
      n++;
    end
    chk("wait_pos_bound", (n < budget), 1'b1);
  endtask

  initial begin
    int last_tick;
    int seen;
    hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_off = 1'b0; commit = 1'b0;
    wr_addr = 2'd0; wr_data = 4'h0;
    en3 = 1'b0; wr_valid3 = 1'b0; wr_off3 = 1'b0; commit3 = 1'b0;
    wr_addr3 = 2'd0; wr_data3 = 4'h0;
    run = 1'b0; t = 0; pend = 1'b0;

    // reset state
    repeat (3) cyc();
    chk("rst_ready", wr_ready, 1'b0);
    rst = 1'b0;
    cyc();

    // enable: blank gap then digit 0, then digit 1
    en = 1'b1;
    cyc();
    chk("first_blank", dig_n, 4'hF);
    wait_pos(1, B, 4 * P);
    chk("digit1_on", dig_n, 4'b1101);

    // write then commit; becomes visible only after the next boundary
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 4'h1; wr_off = 1'b0;
    cyc();
    wr_valid = 1'b0; commit = 1'b1;
    cyc();
    commit = 1'b0;
    wait_pos(2, B + 2, 2 * N * P);
    chk("pre_commit_seg", seg, 7'h7F);
    wait_pos(N - 1, P - 1, 2 * N * P);
    cyc();
    wait_pos(2, B + 2, 2 * N * P);
    chk("commit_vis", seg, 7'b1111001);

    // commit collision: write and commit in the copy cycle
    commit = 1'b1;
    cyc();
    commit = 1'b0;
    wait_pos(N - 1, P - 1, 2 * N * P);
    commit = 1'b1; wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'h8; wr_off = 1'b0;
    cyc();
    commit = 1'b0; wr_valid = 1'b0;
    wait_pos(0, B + 1, 2 * N * P);
    chk("collide_old", seg, 7'h7F);
    cyc();
    wait_pos(0, B + 1, 2 * N * P);
    chk("collide_new", seg, 7'b0000000);

    // disable mid-show of digit 1, then restart at digit 0
    wait_pos(1, B + 5, 2 * N * P);
    en = 1'b0;
    cyc();
    chk("dis_dig_n", dig_n, 4'hF);
    chk("dis_seg", seg, 7'h7F);
    en = 1'b1;
    cyc();
    chk("restart_blank", dig_n, 4'hF);
    repeat (B) cyc();
    chk("restart_d0", dig_n, 4'b1110);

    // reset mid-operation
    rst = 1'b1;
    cyc();
    chk("midrst_dig_n", dig_n, 4'hF);
    chk("midrst_ready", wr_ready, 1'b0);
    rst = 1'b0;
    cyc();

    // long random run with frame period measurement
    last_tick = -1;
    for (int k = 0; k < 10 * N * P + 4; k++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 4'($urandom_range(0, 15));
      wr_off   = ($urandom_range(0, 2) == 0);
      commit   = ($urandom_range(0, 15) == 0);
      cyc();
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) chk("tick_period", cyc_no - last_tick, N * P);
        last_tick = cyc_no;
      end
    end
    wr_valid = 1'b0; commit = 1'b0;
    chk("tick_seen", (last_tick >= 0), 1'b1);

    // NDIG=3 instance: out-of-range address accepted and dropped
    en3 = 1'b1;
    wr_valid3 = 1'b1; wr_addr3 = 2'd3; wr_data3 = 4'h5; wr_off3 = 1'b0;
    #1;
    chk("bad_addr_ready", wr_ready3, 1'b1);
    cyc();
    wr_valid3 = 1'b0; commit3 = 1'b1;
    cyc();
    commit3 = 1'b0;
    for (int k = 0; k < 3 * N3 * P3; k++) begin
      cyc();
      if (dig_n3 !== 3'b111) chk("bad_addr_seg", seg3, 7'h7F);
    end

    // a legal write on the same instance does show up
    wr_valid3 = 1'b1; wr_addr3 = 2'd1; wr_data3 = 4'h1; wr_off3 = 1'b0;
    cyc();
    wr_valid3 = 1'b0; commit3 = 1'b1;
    cyc();
    commit3 = 1'b0;
    seen = 0;
    for (int k = 0; k < 3 * N3 * P3; k++) begin
      cyc();
      if ((dig_n3 === 3'b101) && (seg3 === 7'b1111001)) seen++;
    end
    chk("good_addr_seen", (seen > 0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
